// File: rtl/stall_mem_resp_pkg.sv
// Shared types and constants for the stall_mem_resp multi-cycle data-memory responder.
// The request legality and error helpers live here so every file uses the same rule.
package stall_mem_resp_pkg;

  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 16;
  localparam int DEF_LATENCY   = 4;
  localparam int DEF_MEM_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic req_legal(input logic rd, input logic wr, input logic a0);
    return (rd ^ wr) & ~a0;
  endfunction

  function automatic logic req_err(input logic rd, input logic wr, input logic a0);
    return (rd & wr) | ((rd | wr) & a0);
  endfunction

endpackage

// File: rtl/stall_mem_resp_if.sv
// Memory request bus between the processor (master) and the stalling responder (slave).
interface stall_mem_resp_if;
  import stall_mem_resp_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] data_out;
  logic              stall;
  logic              done;
  logic              err;

  modport master (
    output addr, data_in, rd, wr,
    input  data_out, stall, done, err
  );

  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, stall, done, err
  );

endinterface

// File: rtl/stall_mem_resp_mem_array.sv
// Single-port 16-bit word storage: synchronous write, registered read.
// Only the read register is reset; stored words survive reset.
module stall_mem_resp_mem_array
  import stall_mem_resp_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/stall_mem_resp.sv
// Multi-cycle data-memory responder: latches a legal rd/wr request, stalls for
// LATENCY cycles, then performs the access and pulses done for one cycle.
module stall_mem_resp
  import stall_mem_resp_pkg::*;
#(
  parameter int LATENCY   = DEF_LATENCY,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  stall_mem_resp_if.slave bus
);

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              op_wr_d, op_wr_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              legal;
  logic              mem_we;
  logic              mem_re;
  logic              unused_addr;

  assign legal       = req_legal(bus.rd, bus.wr, bus.addr[0]);
  assign bus.err     = req_err(bus.rd, bus.wr, bus.addr[0]);
  assign unused_addr = ^bus.addr[ADDR_W-1:IDX_W+1];

  // IDLE and DONE both accept a new request, so back-to-back accesses lose no cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (legal) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
          op_wr_d = bus.wr;
          idx_d   = bus.addr[IDX_W:1];
          wdata_d = bus.data_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          mem_we  = op_wr_q;
          mem_re  = ~op_wr_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.stall = (state_q == ST_BUSY);
  assign bus.done  = (state_q == ST_DONE);

  // A reset landing on the final busy edge must abort the write rather than commit it.
  stall_mem_resp_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we & ~rst),
    .re    (mem_re & ~rst),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (bus.data_out)
  );

endmodule

// File: tb/tb_stall_mem_resp.sv
// Bench for stall_mem_resp: LATENCY=4 and LATENCY=1 instances share stimulus and are
// compared every cycle against a timeline-based behavioural model.
module tb_stall_mem_resp;
  import stall_mem_resp_pkg::*;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst_s;
  logic        rd_s;
  logic        wr_s;
  logic [15:0] addr_s;
  logic [15:0] din_s;

  always #5 clk = ~clk;

  stall_mem_resp_if bus0 ();
  stall_mem_resp_if bus1 ();

  assign bus0.rd      = rd_s;
  assign bus0.wr      = wr_s;
  assign bus0.addr    = addr_s;
  assign bus0.data_in = din_s;
  assign bus1.rd      = rd_s;
  assign bus1.wr      = wr_s;
  assign bus1.addr    = addr_s;
  assign bus1.data_in = din_s;

  stall_mem_resp #(.LATENCY(4), .MEM_WORDS(1024), .IDX_W(10)) dut0 (
    .clk (clk),
    .rst (rst_s),
    .bus (bus0.slave)
  );

  stall_mem_resp #(.LATENCY(1), .MEM_WORDS(1024), .IDX_W(10)) dut1 (
    .clk (clk),
    .rst (rst_s),
    .bus (bus1.slave)
  );

  // Model: each access is a point on a timeline, k = edges since acceptance.
  bit          m_act    [NI];
  int          m_k      [NI];
  bit          m_opwr   [NI];
  int          m_idx    [NI];
  logic [15:0] m_wd     [NI];
  logic [15:0] m_mem    [NI][1024];
  bit          m_valid  [NI][1024];
  logic [15:0] m_dout   [NI];
  bit          m_dknown [NI];

  bit chk_on   = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic stall_of(input int i);
    return (i == 0) ? bus0.stall : bus1.stall;
  endfunction

  function automatic logic done_of(input int i);
    return (i == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic err_of(input int i);
    return (i == 0) ? bus0.err : bus1.err;
  endfunction

  function automatic logic [15:0] dout_of(input int i);
    return (i == 0) ? bus0.data_out : bus1.data_out;
  endfunction

  function automatic bit model_err(input bit r, input bit w, input logic [15:0] a);
    int n;
    n = int'(r) + int'(w);
    return (n == 2) || (n == 1 && a[0]);
  endfunction

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      int lat;
      bit can_accept;
      bit legal;
      lat = lat_of(i);
      if (rst_s) begin
        m_act[i]    = 1'b0;
        m_k[i]      = 0;
        m_dout[i]   = 16'h0000;
        m_dknown[i] = 1'b1;
      end else begin
        can_accept = !m_act[i] || (m_k[i] >= lat);
        legal      = (rd_s != wr_s) && !addr_s[0];
        if (m_act[i] && m_k[i] < lat) begin
          m_k[i]++;
          if (m_k[i] == lat) begin
            if (m_opwr[i]) begin
              m_mem[i][m_idx[i]]   = m_wd[i];
              m_valid[i][m_idx[i]] = 1'b1;
            end else begin
              m_dout[i]   = m_mem[i][m_idx[i]];
              m_dknown[i] = m_valid[i][m_idx[i]];
            end
          end
        end else begin
          m_act[i] = 1'b0;
        end
        if (can_accept && legal) begin
          m_act[i]  = 1'b1;
          m_k[i]    = 0;
          m_opwr[i] = wr_s;
          m_idx[i]  = (int'(addr_s) / 2) % 1024;
          m_wd[i]   = din_s;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        check_output($sformatf("stall%0d", i), stall_of(i), (m_act[i] && m_k[i] < lat_of(i)));
        check_output($sformatf("done%0d", i), done_of(i), (m_act[i] && m_k[i] == lat_of(i)));
        check_output($sformatf("err%0d", i), err_of(i), model_err(rd_s, wr_s, addr_s));
        if (m_dknown[i]) begin
          check_output($sformatf("data_out%0d", i), dout_of(i), m_dout[i]);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic apply_stimulus(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    rd_s   = r;
    wr_s   = w;
    addr_s = a;
    din_s  = d;
  endtask

  task automatic issue(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    apply_stimulus(r, w, a, d);
    cycle();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wait_done(input int inst, input int max_c, output int stalls);
    bit got;
    got    = 1'b0;
    stalls = 0;
    for (int c = 0; c < max_c; c++) begin
      if (done_of(inst)) begin
        got = 1'b1;
        break;
      end
      if (stall_of(inst)) stalls++;
      cycle();
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL wait_done%0d: got no done, expected done within %0d cycles", inst, max_c);
    end
  endtask

  initial begin
    int st;
    int r;
    logic [15:0] a;
    rst_s = 1'b1;
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    cycle();
    cycle();
    rst_s  = 1'b0;
    chk_on = 1'b1;
    check_output("rst_stall", bus0.stall, 16'h0);
    check_output("rst_done", bus0.done, 16'h0);
    check_output("rst_data_out", bus0.data_out, 16'h0000);

    apply_stimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    #1;
    check_output("t1_err", bus0.err, 16'h0);
    cycle();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_done(0, 20, st);
    check_output("t1_stall_cycles", 16'(st), 16'd4);
    check_output("t1_done", bus0.done, 16'h1);
    cycle();
    check_output("t1_done_one_cycle", bus0.done, 16'h0);

    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    wait_done(0, 20, st);
    check_output("t2_stall_cycles", 16'(st), 16'd4);
    check_output("t2_read", bus0.data_out, 16'hBEEF);
    repeat (3) cycle();
    check_output("t2_hold", bus0.data_out, 16'hBEEF);

    apply_stimulus(1'b1, 1'b1, 16'h0010, 16'h0000);
    #1;
    check_output("t3_err_both", bus0.err, 16'h1);
    cycle();
    apply_stimulus(1'b1, 1'b0, 16'h0011, 16'h0000);
    #1;
    check_output("t3_err_odd", bus0.err, 16'h1);
    check_output("t3_no_stall", bus0.stall, 16'h0);
    cycle();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_output("t3_no_stall2", bus0.stall, 16'h0);
    repeat (5) cycle();
    check_output("t3_no_done", bus0.done, 16'h0);

    issue(1'b0, 1'b1, 16'h0810, 16'hCAFE);
    wait_done(0, 20, st);
    issue(1'b0, 1'b1, 16'h0020, 16'h5555);
    check_output("t4_b2b_stall", bus0.stall, 16'h1);
    wait_done(0, 20, st);
    check_output("t4_b2b_stall_cycles", 16'(st), 16'd4);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    wait_done(0, 20, st);
    check_output("t4_alias", bus0.data_out, 16'hCAFE);

    issue(1'b0, 1'b1, 16'h0020, 16'h1234);
    cycle();
    rst_s = 1'b1;
    cycle();
    rst_s = 1'b0;
    check_output("t5_rst_stall", bus0.stall, 16'h0);
    check_output("t5_rst_done", bus0.done, 16'h0);
    check_output("t5_rst_data_out", bus0.data_out, 16'h0000);
    issue(1'b1, 1'b0, 16'h0020, 16'h0000);
    wait_done(0, 20, st);
    check_output("t5_old_value", bus0.data_out, 16'h5555);

    repeat (2) cycle();
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    wait_done(1, 10, st);
    check_output("t6_stall_cycles", 16'(st), 16'd1);
    check_output("t6_read", bus1.data_out, 16'hCAFE);
    repeat (6) cycle();

    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      a = 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 15) << 1));
      if ($urandom_range(0, 19) == 0) a[0] = 1'b1;
      rst_s = ($urandom_range(0, 59) == 0);
      if (r < 40)      apply_stimulus(1'b0, 1'b0, a, 16'($urandom));
      else if (r < 68) apply_stimulus(1'b1, 1'b0, a, 16'($urandom));
      else if (r < 95) apply_stimulus(1'b0, 1'b1, a, 16'($urandom));
      else             apply_stimulus(1'b1, 1'b1, a, 16'($urandom));
      cycle();
    end
    rst_s = 1'b0;
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (8) cycle();
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
